imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Upstream loader for the single-cycle CPU: accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them into instruction memory. Holds the CPU in reset until a complete, checksum-verified program image is loaded, then releases it. Sits between the host byte source, the instruction-memory write port and the CPU reset input.

## Interface
- ADDR_W, 8: instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
- reload  in  1  one-cycle pulse; restarts loading from DONE or ERR, ignored elsewhere.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  CPU reset; high while the image is not yet valid.
- busy  out  1  high in LEN_HI, LEN_LO, DATA, CSUM.
- done  out  1  image loaded and verified.
- err  out  1  image rejected.
- word_cnt  out  ADDR_W+1  words written in the current load.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, MSB first (byte 0 → [31:24]), then one checksum byte.
- Checksum rule: the XOR of every frame byte, length and checksum bytes included, must equal 0x00.
- States: LEN_HI → LEN_LO → DATA → CSUM → DONE | ERR.
  - LEN_LO: if N = 0, next state is CSUM. If N > DEPTH, next state is ERR and the remaining stream is not consumed. Otherwise next state is DATA.
  - DATA: byte counter 0..3. On the 4th byte, the word is written and the word index increments. After word N-1, next state is CSUM.
  - CSUM: if the running XOR, checksum included, is 0x00, go to DONE; otherwise go to ERR.
  - DONE / ERR: in_ready = 0. A reload pulse resets the word index, byte counter, XOR and word_cnt, and moves to LEN_HI.
- in_ready = 1 in every receive state; no internal backpressure.
- cpu_rst = 1 in every state except DONE.
- Words already written before an ERR stay in memory; cpu_rst stays high, so they are never executed.
- Instruction memory is never cleared by this block.

## Timing
- Reset values: state LEN_HI, in_ready 1, imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst 1, busy 1, done 0, err 0, word_cnt 0.
- Write latency: imem_we is registered and high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - imem_addr and imem_wdata are valid in that same cycle.
  - word_cnt increments in that same cycle.
- Release latency: the cycle after the good checksum byte is accepted, the state is DONE, done = 1 and cpu_rst = 0.
- Error latency: err = 1 the cycle after the failing byte is accepted (bad checksum byte or LEN_LO with N > DEPTH).
- Gaps: in_valid may drop between any two bytes. No state advances without a transfer.
- If reload and in_valid are asserted together in DONE, no byte is accepted that cycle. The first byte is accepted no earlier than the next cycle.
- rst mid-load:
  - returns to LEN_HI next cycle;
  - the partial word is discarded and no imem_we is issued for it;
  - cpu_rst is forced to 1.
- A last-word write and the checksum byte can land in adjacent cycles; both must be honoured.

## Structure
- Shared package `boot_pkg`:
  - state enum (LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - constants BYTES_PER_WORD = 4, LEN_BYTES = 2, CSUM_OK = 8'h00.
- One sub-module `byte_packer`:
  - 32-bit shift register plus 2-bit byte counter;
  - outputs word_valid and word.
- The top holds the FSM, word index, XOR accumulator and outputs.

## Test plan
- Good load: N = 2 with words 0x8C220004 and 0x08000000, correct checksum.
  - Expect writes to addr 0 then addr 1 with exactly those words.
  - Expect done = 1 and cpu_rst falling the cycle after the checksum byte.
  - Expect word_cnt = 2.
- Bad checksum: same image with checksum XOR 0x01.
  - Expect both writes still issued, then err = 1, cpu_rst = 1, in_ready = 0.
- Boundaries:
  - N = 0 with checksum 0x00 → done, no imem_we.
  - With ADDR_W = 8, N = 257 → err after LEN_LO, no writes.
- Handshake gaps: random in_valid gaps of 0–5 cycles on the good load → writes and results identical to the gap-free run.
- Reset mid-word: rst asserted after 2 bytes of word 1.
  - Expect no write for word 1 and state LEN_HI.
  - Expect a subsequent full load to succeed from addr 0.
- Reload: after DONE, pulse reload and send a new N = 1 image.
  - Expect cpu_rst to rise the cycle after the pulse and to fall after the new checksum.
  - Expect addr 0 overwritten.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam int         LEN_BYTES      = 2;
    localparam logic [7:0] CSUM_OK        = 8'h00;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the boot loader.
// Latency: n/a (wires only).
// Backpressure: in_ready from the loader gates the byte stream.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/byte_packer.sv
// Packs four stream bytes MSB-first into one 32-bit instruction word.
// Latency: word_valid/word are combinational with the 4th accepted byte.
// Backpressure: none; every byte_vld is consumed.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    assign word_valid = byte_vld && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word       = {shift_q, byte_dat};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (byte_vld) begin
            shift_q <= {shift_q[15:0], byte_dat};
            cnt_q   <= cnt_q + 2'd1;
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed image into imem; holds the CPU in reset until it verifies.
// Latency: imem write 1 cycle after a word's 4th byte; done/err 1 cycle after the deciding byte.
// Backpressure: in_ready high in every receive state, low in DONE/ERR until reload.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus,
    input  logic              reload,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q;
    logic [15:0]       len_q;
    logic [7:0]        xor_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;

    logic              xfer;
    logic              restart;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       len_in;
    logic              last_word;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign restart   = reload && ((state_q == DONE) || (state_q == ERR));
    assign len_in    = {len_hi_q, bus.in_data};
    assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (restart),
        .byte_vld   (xfer && (state_q == DATA)),
        .byte_dat   (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= LEN_HI;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LEN_HI: if (xfer) state_d = LEN_LO;
            LEN_LO: begin
                // Oversized images are rejected before any payload is consumed.
                if (xfer) begin
                    if (len_in == 16'd0)                  state_d = CSUM;
                    else if (32'(len_in) > 32'(DEPTH))    state_d = ERR;
                    else                                  state_d = DATA;
                end
            end
            DATA:   if (word_valid && last_word) state_d = CSUM;
            CSUM:   if (xfer) state_d = ((xor_q ^ bus.in_data) == CSUM_OK) ? DONE : ERR;
            DONE,
            ERR:    if (reload) state_d = LEN_HI;
            default: state_d = LEN_HI;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        cpu_rst      = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        case (state_q)
            LEN_HI, LEN_LO, DATA, CSUM: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi_q     <= '0;
            len_q        <= '0;
            xor_q        <= '0;
            word_cnt_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            imem_we_q <= word_valid;
            if (word_valid) begin
                imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                imem_wdata_q <= word;
                word_cnt_q   <= word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (restart) begin
                xor_q      <= '0;
                word_cnt_q <= '0;
            end else if (xfer) begin
                xor_q <= xor_q ^ bus.in_data;
                if (state_q == LEN_HI) len_hi_q <= bus.in_data;
                if (state_q == LEN_LO) len_q    <= len_in;
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign word_cnt       = word_cnt_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames plus random frames/gaps, checked every cycle
// against a frame-level model computed from the bytes accepted so far.
module tb_imem_boot_loader;
    import boot_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            reload = 1'b0;
    logic            cpu_rst, busy, done, err;
    logic [ADDR_W:0] word_cnt;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .reload   (reload),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: bytes accepted in the current load, and the edge on which the latest one landed.
    logic [7:0] pfx[$];
    int         last_acc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_len();
        if (pfx.size() < LEN_BYTES) return 0;
        return int'({pfx[0], pfx[1]});
    endfunction

    // 0 = still receiving, 1 = image verified, 2 = image rejected
    function automatic int m_status();
        int         n;
        logic [7:0] x;
        if (pfx.size() < LEN_BYTES) return 0;
        n = m_len();
        if (n > DEPTH) return 2;
        if (pfx.size() < LEN_BYTES + BYTES_PER_WORD * n + 1) return 0;
        x = 8'h00;
        foreach (pfx[i]) x = x ^ pfx[i];
        return (x == 8'h00) ? 1 : 2;
    endfunction

    function automatic int m_wcnt();
        int k;
        if (pfx.size() < LEN_BYTES || m_len() > DEPTH) return 0;
        k = (pfx.size() - LEN_BYTES) / BYTES_PER_WORD;
        return (k < m_len()) ? k : m_len();
    endfunction

    function automatic bit m_we();
        int k;
        if (last_acc != cyc) return 1'b0;
        if (pfx.size() < LEN_BYTES + BYTES_PER_WORD || m_len() > DEPTH) return 1'b0;
        k = pfx.size() - LEN_BYTES;
        return (k % BYTES_PER_WORD == 0) && (k / BYTES_PER_WORD <= m_len());
    endfunction

    function automatic logic [31:0] m_last_word();
        int b;
        b = pfx.size() - BYTES_PER_WORD;
        return {pfx[b], pfx[b+1], pfx[b+2], pfx[b+3]};
    endfunction

    always @(negedge clk) begin
        int st;
        bit we;
        if (chk_en) begin
            st = m_status();
            we = m_we();
            chk("in_ready", 32'(bus.in_ready), 32'(st == 0));
            chk("busy",     32'(busy),         32'(st == 0));
            chk("cpu_rst",  32'(cpu_rst),      32'(st != 1));
            chk("done",     32'(done),         32'(st == 1));
            chk("err",      32'(err),          32'(st == 2));
            chk("word_cnt", 32'(word_cnt),     32'(m_wcnt()));
            chk("imem_we",  32'(bus.imem_we),  32'(we));
            if (we) begin
                chk("imem_addr",  32'(bus.imem_addr), 32'(m_wcnt() - 1));
                chk("imem_wdata", bus.imem_wdata,     m_last_word());
            end
        end
    end

    logic [31:0]        shadow [DEPTH];
    logic [ADDR_W+31:0] wlog[$];
    logic [ADDR_W+31:0] golden[$];
    int                 wr_cnt = 0;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            shadow[bus.imem_addr] = bus.imem_wdata;
            wlog.push_back({bus.imem_addr, bus.imem_wdata});
            wr_cnt++;
        end
    end

    logic [7:0] frm[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accept;
        repeat (gap) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        accept = (m_status() == 0);
        tick();
        if (accept) begin
            pfx.push_back(b);
            last_acc = cyc;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic frm_start(input int n);
        frm.delete();
        frm.push_back(8'(n >> 8));
        frm.push_back(8'(n));
    endtask

    task automatic frm_word(input logic [31:0] w);
        frm.push_back(w[31:24]);
        frm.push_back(w[23:16]);
        frm.push_back(w[15:8]);
        frm.push_back(w[7:0]);
    endtask

    task automatic frm_end(input bit bad);
        logic [7:0] x;
        x = 8'h00;
        foreach (frm[i]) x = x ^ frm[i];
        frm.push_back(x ^ {7'b0, bad});
    endtask

    task automatic send_frame(input int maxgap, input int upto);
        for (int i = 0; i < upto && i < frm.size(); i++)
            send_byte(frm[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic do_reload(input bit with_valid);
        bit was_final;
        was_final    = (m_status() != 0);
        reload       = 1'b1;
        bus.in_valid = with_valid && was_final;
        bus.in_data  = 8'h5A;
        tick();
        if (was_final) begin
            pfx.delete();
            last_acc = -1;
        end
        reload       = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        pfx.delete();
        last_acc = -1;
        rst      = 1'b0;
    endtask

    task automatic good_frame();
        frm_start(2);
        frm_word(32'h8C22_0004);
        frm_word(32'h0800_0000);
        frm_end(1'b0);
    endtask

    initial begin
        int  w0;
        bit  ok;
        int  n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        tick();
        tick();
        chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
        chk("rst_imem_we",    32'(bus.imem_we),    32'd0);
        chk("rst_imem_addr",  32'(bus.imem_addr),  32'd0);
        chk("rst_imem_wdata", bus.imem_wdata,      32'd0);
        chk("rst_cpu_rst",    32'(cpu_rst),        32'd1);
        chk("rst_busy",       32'(busy),           32'd1);
        chk("rst_done",       32'(done),           32'd0);
        chk("rst_err",        32'(err),            32'd0);
        chk("rst_word_cnt",   32'(word_cnt),       32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Good load, no gaps
        good_frame();
        chk("good_csum_byte", 32'(frm[10]), 32'hA0);
        w0 = wr_cnt;
        wlog.delete();
        send_frame(0, frm.size());
        chk("good_done",    32'(done),     32'd1);
        chk("good_cpu_rst", 32'(cpu_rst),  32'd0);
        chk("good_wcnt",    32'(word_cnt), 32'd2);
        tick();
        chk("good_writes",  32'(wr_cnt - w0), 32'd2);
        chk("good_mem0",    shadow[0],     32'h8C22_0004);
        chk("good_mem1",    shadow[1],     32'h0800_0000);
        golden = wlog;

        // Reload with a byte offered in the same cycle, then the gapped run
        do_reload(1'b1);
        chk("reload_cpu_rst", 32'(cpu_rst),  32'd1);
        chk("reload_wcnt",    32'(word_cnt), 32'd0);
        wlog.delete();
        send_frame(5, frm.size());
        tick();
        ok = (wlog.size() == golden.size());
        foreach (wlog[i]) if (i < golden.size() && wlog[i] !== golden[i]) ok = 1'b0;
        chk("gap_writes_match", 32'(ok), 32'd1);
        chk("gap_done", 32'(done), 32'd1);

        // Bad checksum
        do_reload(1'b0);
        frm_start(2);
        frm_word(32'h8C22_0004);
        frm_word(32'h0800_0000);
        frm_end(1'b1);
        w0 = wr_cnt;
        send_frame(0, frm.size());
        chk("bad_err",      32'(err),          32'd1);
        chk("bad_cpu_rst",  32'(cpu_rst),      32'd1);
        chk("bad_in_ready", 32'(bus.in_ready), 32'd0);
        send_byte(8'h33, 0);
        chk("bad_writes",   32'(wr_cnt - w0),  32'd2);

        // Empty image
        do_reload(1'b0);
        frm_start(0);
        frm_end(1'b0);
        w0 = wr_cnt;
        send_frame(1, frm.size());
        tick();
        chk("n0_done",   32'(done),         32'd1);
        chk("n0_writes", 32'(wr_cnt - w0),  32'd0);

        // Oversized image: rejected after LEN_LO, rest of stream untouched
        do_reload(1'b0);
        frm_start(DEPTH + 1);
        w0 = wr_cnt;
        send_frame(0, frm.size());
        chk("big_err", 32'(err), 32'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        chk("big_writes", 32'(wr_cnt - w0), 32'd0);

        // Reset after two bytes of word 1
        do_reload(1'b0);
        frm_start(2);
        frm_word(32'h1111_1111);
        frm_word(32'h2222_2222);
        frm_end(1'b0);
        w0 = wr_cnt;
        send_frame(0, LEN_BYTES + BYTES_PER_WORD + 2);
        do_reset();
        tick();
        tick();
        chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd1);
        chk("mid_rst_busy",   32'(busy),        32'd1);
        chk("mid_rst_wcnt",   32'(word_cnt),    32'd0);
        good_frame();
        send_frame(2, frm.size());
        tick();
        chk("after_rst_done", 32'(done),  32'd1);
        chk("after_rst_mem0", shadow[0],  32'h8C22_0004);

        // Reload with a fresh single-word image overwriting addr 0
        do_reload(1'b0);
        frm_start(1);
        frm_word(32'hDEAD_BEEF);
        frm_end(1'b0);
        send_frame(0, frm.size());
        chk("n1_cpu_rst", 32'(cpu_rst), 32'd0);
        tick();
        chk("n1_mem0", shadow[0], 32'hDEAD_BEEF);

        // Random frames, gaps, reloads and mid-frame resets
        for (int it = 0; it < 40; it++) begin
            if (m_status() != 0) do_reload(1'($urandom));
            n = ($urandom % 10 == 0) ? DEPTH + 1 + int'($urandom % 50) : int'($urandom_range(0, 5));
            frm_start(n);
            if (n <= DEPTH) begin
                for (int k = 0; k < n; k++) frm_word($urandom);
                frm_end($urandom % 4 == 0);
            end
            if ($urandom % 8 == 0) begin
                send_frame(3, int'($urandom_range(0, frm.size() - 1)));
                do_reset();
            end else begin
                send_frame(3, frm.size());
                if (n > DEPTH) send_byte(8'($urandom), 0);
            end
            repeat (int'($urandom_range(0, 3))) tick();
        end

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
